// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Parallel-to-serial front end for the sequence detector. WIDTH-bit words are
// accepted over a valid/ready handshake and shifted out one bit per clock on
// ser_out. A single holding register lets a second word queue up while the
// current one is shifting, so back-to-back words stream with no idle bit in
// between.
//
// Handshake: a word is accepted at a rising edge where data_valid && data_ready.
// data_ready is simply "holding register empty". data_in is only sampled at the
// accept edge; the producer may change it freely while data_ready is low.
//
// Parameters:
//   WIDTH     word length in bits (>= 2)
//   MSB_FIRST 1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_BIT  level on ser_out whenever no data bit is presented
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   data_in    parallel word to serialize
//   data_valid data_in is valid
//   data_ready block can accept a word this cycle
//   ser_out    registered serial bit (feeds the detector's in_seq)
//   ser_valid  registered, ser_out carries a data bit
//   word_done  registered, high while ser_out carries the last bit of a word
//   busy       a word is shifting or the holding register is occupied
//   state_dbg  current FSM state (0 = IDLE, 1 = SHIFT) for checkers
// -----------------------------------------------------------------------------
module bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy,
  output logic             state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_full;

  // Control decode
  logic             accept;
  logic             last_bit;
  logic             load_en;
  logic             load_from_hold;
  logic             to_hold;
  logic [WIDTH-1:0] load_word;

  // Bit that leaves first from a word, honoring the bit order.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return w[WIDTH-1];
    else           return w[0];
  endfunction

  // Shift the word so the next bit to present sits in the first_bit slot.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return {w[WIDTH-2:0], 1'b0};
    else           return {1'b0, w[WIDTH-1:1]};
  endfunction

  always_comb begin
    accept         = 1'b0;
    last_bit       = 1'b0;
    load_from_hold = 1'b0;
    load_en        = 1'b0;
    to_hold        = 1'b0;
    load_word      = data_in;

    accept   = data_valid && !hold_full;
    last_bit = (state == SHIFT) && (cnt == CNT_ZERO);

    // At the last-bit edge a held word has priority. A direct accept cannot
    // collide with it because data_ready is low whenever hold_full is set.
    load_from_hold = last_bit && hold_full;

    if (load_from_hold) begin
      load_en   = 1'b1;
      load_word = hold_reg;
    end else if (accept && ((state == IDLE) || last_bit)) begin
      load_en   = 1'b1;
      load_word = data_in;
    end

    // Mid-word accept parks the word in the holding register.
    to_hold = accept && (state == SHIFT) && (cnt != CNT_ZERO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= CNT_ZERO;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      ser_out   <= IDLE_BIT;
      ser_valid <= 1'b0;
      word_done <= 1'b0;
    end else begin
      // Shift path
      if (load_en) begin
        // The first bit goes straight onto ser_out; shreg keeps the rest.
        state     <= SHIFT;
        shreg     <= advance(load_word);
        ser_out   <= first_bit(load_word);
        ser_valid <= 1'b1;
        cnt       <= CNT_LAST;
        word_done <= 1'b0;
      end else if ((state == SHIFT) && (cnt != CNT_ZERO)) begin
        shreg     <= advance(shreg);
        ser_out   <= first_bit(shreg);
        ser_valid <= 1'b1;
        cnt       <= cnt - CNT_ONE;
        // Counter reaching zero means this edge presents the final bit.
        word_done <= (cnt == CNT_ONE);
      end else begin
        state     <= IDLE;
        ser_out   <= IDLE_BIT;
        ser_valid <= 1'b0;
        cnt       <= CNT_ZERO;
        word_done <= 1'b0;
      end

      // Holding register
      if (load_from_hold) begin
        hold_full <= 1'b0;
      end else if (to_hold) begin
        hold_reg  <= data_in;
        hold_full <= 1'b1;
      end
    end
  end

  assign data_ready = !hold_full;
  assign busy       = (state == SHIFT) || hold_full;
  assign state_dbg  = state;

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//
// Bench for bit_serializer. u_dut is the MSB-first instance fed through the
// shared scoreboard; u_lsb is an LSB-first instance checked inline.
// Inputs are driven on the falling edge, outputs are sampled on the falling
// edge, the DUT updates on the rising edge.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

  localparam int W = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // MSB-first instance
  logic [W-1:0] data_in    = '0;
  logic         data_valid = 1'b0;
  logic         data_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         word_done;
  logic         busy;
  logic         state_dbg;

  // LSB-first instance
  logic [W-1:0] data_in_l    = '0;
  logic         data_valid_l = 1'b0;
  logic         data_ready_l;
  logic         ser_out_l;
  logic         ser_valid_l;
  logic         word_done_l;
  logic         busy_l;
  logic         state_dbg_l;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .word_done  (word_done),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in_l),
    .data_valid (data_valid_l),
    .data_ready (data_ready_l),
    .ser_out    (ser_out_l),
    .ser_valid  (ser_valid_l),
    .word_done  (word_done_l),
    .busy       (busy_l),
    .state_dbg  (state_dbg_l)
  );

  // Scoreboard: each entry is {word_done, ser_out} for one data-bit cycle.
  logic [1:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] cap    = '0;
  int          cap_n  = 0;

  task automatic push_word(input logic [W-1:0] w);
    logic b;
    for (int i = 0; i < W; i++) begin
      b = w[W-1-i];
      exp_q.push_back({(i == W-1), b});
    end
  endtask

  // Monitor: every data bit is popped and compared; idle cycles must be quiet.
  always @(negedge clk) begin
    logic [1:0] e;
    if (ser_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor_extra_bit: ser_out=%b with nothing expected", ser_out);
      end else begin
        e = exp_q.pop_front();
        if ({word_done, ser_out} !== e) begin
          errors++;
          $display("FAIL monitor_bit: word_done/ser_out=%b%b expected %b%b",
                   word_done, ser_out, e[1], e[0]);
        end
      end
      cap = {cap[14:0], ser_out};
      cap_n++;
    end else begin
      checks++;
      if (word_done !== 1'b0 || ser_out !== 1'b0 || ser_valid !== 1'b0) begin
        errors++;
        $display("FAIL monitor_idle: ser_valid=%b ser_out=%b word_done=%b expected 0 0 0",
                 ser_valid, ser_out, word_done);
      end
    end
  end

  // Driver: present w and hold it until the accept edge has passed.
  task automatic send_word(input logic [W-1:0] w);
    int budget;
    @(negedge clk);
    data_in    = w;
    data_valid = 1'b1;
    budget     = 0;
    while (data_ready !== 1'b1 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (data_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: data_ready=%b expected 1 within 40 cycles", data_ready);
    end else begin
      push_word(w);
    end
    @(posedge clk);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    data_valid = 1'b0;
    data_in    = W'($urandom);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b expected 0 within %0d cycles", busy, limit);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({ser_out, ser_valid, word_done, busy, data_ready, state_dbg} !== 6'b000010) begin
      errors++;
      $display("FAIL reset_values: out/valid/done/busy/ready/state=%b expected 000010",
               {ser_out, ser_valid, word_done, busy, data_ready, state_dbg});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [W-1:0] pat;
    pat = 8'hA5;
    send_word(pat);              // accept edge T
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);            // cycle T+c
      if (c == 1) begin
        data_valid = 1'b0;
        data_in    = 8'h3C;
      end
      checks++;
      if (ser_valid !== (c <= 8) || word_done !== (c == 8)) begin
        errors++;
        $display("FAIL single_flags c=%0d: ser_valid=%b word_done=%b expected %b %b",
                 c, ser_valid, word_done, (c <= 8), (c == 8));
      end
      if (c <= 8) begin
        checks++;
        if (ser_out !== pat[8-c]) begin
          errors++;
          $display("FAIL single_bit c=%0d: ser_out=%b expected %b", c, ser_out, pat[8-c]);
        end
      end else begin
        checks++;
        if (ser_out !== 1'b0 || busy !== 1'b0 || state_dbg !== 1'b0) begin
          errors++;
          $display("FAIL single_end: ser_out=%b busy=%b state=%b expected 0 0 0",
                   ser_out, busy, state_dbg);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    send_word(8'hAA);            // edge T
    send_word(8'h0F);            // edge T+1, goes to the holding register
    for (int c = 2; c <= 17; c++) begin
      @(negedge clk);            // cycle T+c
      // Garbage on data_in while not ready must be ignored.
      if (c == 2) data_in = W'($urandom);
      if (c == 8) begin
        data_valid = 1'b0;
        data_in    = 8'hFF;
      end
      checks++;
      if (data_ready !== !(c <= 8)) begin
        errors++;
        $display("FAIL b2b_ready c=%0d: data_ready=%b expected %b", c, data_ready, !(c <= 8));
      end
      checks++;
      if (ser_valid !== (c <= 16) || word_done !== (c == 8 || c == 16)) begin
        errors++;
        $display("FAIL b2b_flags c=%0d: ser_valid=%b word_done=%b expected %b %b",
                 c, ser_valid, word_done, (c <= 16), (c == 8 || c == 16));
      end
    end
  endtask

  task automatic test_direct_reload();
    int n;
    send_word(8'h55);            // edge T
    n = 0;
    do begin
      @(negedge clk);
      data_valid = 1'b0;
      n++;
      checks++;
      if (data_ready !== 1'b1) begin
        errors++;
        $display("FAIL reload_ready_first: data_ready=%b expected 1", data_ready);
      end
    end while (word_done !== 1'b1 && n < 20);
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL reload_last_cycle: word_done seen after %0d cycles expected 8", n);
    end
    // Present the next word in the last-bit cycle.
    data_in    = 8'hF0;
    data_valid = 1'b1;
    push_word(8'hF0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) data_valid = 1'b0;
      checks++;
      if (ser_valid !== (c <= 8) || data_ready !== 1'b1 || word_done !== (c == 8)) begin
        errors++;
        $display("FAIL reload_second c=%0d: valid/ready/done=%b%b%b expected %b1%b",
                 c, ser_valid, data_ready, word_done, (c <= 8), (c == 8));
      end
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] words[2];
    words[0] = 8'h01;
    words[1] = 8'hB2;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      data_in_l    = words[k];
      data_valid_l = 1'b1;
      @(negedge clk);            // accept edge passed, cycle T+1
      data_valid_l = 1'b0;
      for (int c = 1; c <= 9; c++) begin
        if (c <= 8) begin
          checks++;
          if (ser_valid_l !== 1'b1 || ser_out_l !== words[k][c-1] || word_done_l !== (c == 8)) begin
            errors++;
            $display("FAIL lsb_bit w=%h c=%0d: valid/out/done=%b%b%b expected 1%b%b",
                     words[k], c, ser_valid_l, ser_out_l, word_done_l, words[k][c-1], (c == 8));
          end
        end else begin
          checks++;
          if (ser_valid_l !== 1'b0 || ser_out_l !== 1'b0 || busy_l !== 1'b0) begin
            errors++;
            $display("FAIL lsb_end: valid/out/busy=%b%b%b expected 000",
                     ser_valid_l, ser_out_l, busy_l);
          end
        end
        if (c < 9) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    send_word(8'hFF);            // edge T
    send_word(8'h3C);            // edge T+1, held
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      if (c == 2) data_valid = 1'b0;
    end
    checks++;
    if (data_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_hold: data_ready=%b expected 0 before reset", data_ready);
    end
    // Reset inside the 4th-bit cycle, away from any clock edge.
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    checks++;
    if ({ser_out, ser_valid, word_done, data_ready, busy} !== 5'b00010) begin
      errors++;
      $display("FAIL rst_mid_async: out/valid/done/ready/busy=%b expected 00010",
               {ser_out, ser_valid, word_done, data_ready, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (ser_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_flush c=%0d: ser_valid=%b busy=%b expected 0 0",
                 c, ser_valid, busy);
      end
    end
  endtask

  task automatic test_detector_stream();
    #1;
    cap   = '0;
    cap_n = 0;
    send_word(8'h55);
    send_word(8'h55);
    drop_valid();
    wait_idle(40);
    checks++;
    if (cap_n != 16 || cap !== 16'b0101010101010101) begin
      errors++;
      $display("FAIL detector_stream: bits=%0d pattern=%b expected 16 0101010101010101",
               cap_n, cap);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      send_word(W'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) begin
        drop_valid();
        repeat ($urandom_range(0, 10)) @(negedge clk);
      end
    end
    drop_valid();
    wait_idle(200);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    drop_valid();
    wait_idle(40);
    test_direct_reload();
    test_lsb_first();
    test_reset_mid_word();
    test_detector_stream();
    test_random();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d bits left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
